// File: rtl/mips_mem_loader_if.sv
// Byte-stream input and word write port of the MIPS boot/memory loader.
// The slave side is the loader; the master side is the stream source / storage sink.
interface mips_mem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_sel, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_sel, wr_addr, wr_data
  );
endinterface

// File: rtl/mips_mem_loader.sv
// Boot loader: parses header/count/address/data byte commands into big-endian word writes; holds the CPU in reset until run.
// Write strobe one cycle after the 4th data byte; in_ready drops only in WRITE. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module mips_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic             clk_CPU,
  input  logic             rstn_CPU,
  mips_mem_loader_if.slave loadBus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, COUNT, ADDR, DATA, WRITE
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } stateT;

  stateT             state, nextState;
  logic              xfer, isLoadHdr, lastWord;
  logic [1:0]        byteIdx, selQ, wrSelQ;
  logic [7:0]        wordsLeft;
  logic [23:0]       shiftQ;
  logic [ADDR_W-1:0] addrCnt, wrAddrQ;
  logic [31:0]       wrDataQ;
  logic              holdQ, errQ;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csumQ;
`endif

  assign loadBus.in_ready = rstn_CPU && (state != WRITE);
  assign xfer             = loadBus.in_valid && loadBus.in_ready;
  assign isLoadHdr        = loadBus.in_data <= 8'h02;
  assign lastWord         = wordsLeft == 8'd0;

  assign loadBus.wr_en   = state == WRITE;
  assign loadBus.wr_sel  = wrSelQ;
  assign loadBus.wr_addr = wrAddrQ;
  assign loadBus.wr_data = wrDataQ;
  assign busy            = state != IDLE;
  assign cpu_hold        = holdQ;
  assign err             = errQ;

  always_ff @(posedge clk_CPU or negedge rstn_CPU) begin
    if (!rstn_CPU) state <= IDLE;
    else           state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      // A load header aimed at a running CPU is dropped here; the datapath flags it.
      IDLE:  if (xfer && isLoadHdr && holdQ) nextState = COUNT;
      COUNT: if (xfer) nextState = ADDR;
      ADDR:  if (xfer) nextState = DATA;
      DATA:  if (xfer && byteIdx == 2'd3) nextState = WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE: nextState = lastWord ? CHK : DATA;
      CHK:   if (xfer) nextState = IDLE;
`else
      WRITE: nextState = lastWord ? IDLE : DATA;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_CPU or negedge rstn_CPU) begin
    if (!rstn_CPU) begin
      byteIdx   <= 2'd0;
      selQ      <= 2'd0;
      wrSelQ    <= 2'd0;
      wordsLeft <= 8'd0;
      shiftQ    <= 24'd0;
      addrCnt   <= '0;
      wrAddrQ   <= '0;
      wrDataQ   <= 32'd0;
      holdQ     <= 1'b1;
      errQ      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csumQ     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          csumQ <= 8'd0;
`endif
          if (isLoadHdr) begin
            if (holdQ) selQ <= loadBus.in_data[1:0];
            else       errQ <= 1'b1;
          end else if (loadBus.in_data == 8'hFF) begin
            holdQ <= 1'b0;
          end else if (loadBus.in_data == 8'hFE) begin
            holdQ <= 1'b1;
          end else begin
            errQ <= 1'b1;
          end
        end
        COUNT: if (xfer) wordsLeft <= loadBus.in_data;
        ADDR: if (xfer) begin
          addrCnt <= ADDR_W'(loadBus.in_data);
          byteIdx <= 2'd0;
        end
        DATA: if (xfer) begin
          shiftQ  <= {shiftQ[15:0], loadBus.in_data};
          byteIdx <= byteIdx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csumQ   <= csumQ ^ loadBus.in_data;
`endif
          // Write-port registers only change on entry to WRITE so they sit still otherwise.
          if (byteIdx == 2'd3) begin
            wrDataQ <= {shiftQ, loadBus.in_data};
            wrAddrQ <= addrCnt;
            wrSelQ  <= selQ;
          end
        end
        WRITE: begin
          wordsLeft <= wordsLeft - 8'd1;
          // The register bank has 32 entries, so its address wraps at 32.
          if (selQ == 2'd2) addrCnt <= ADDR_W'(5'(addrCnt[4:0] + 5'd1));
          else              addrCnt <= addrCnt + 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (xfer && loadBus.in_data != csumQ) errQ <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_loader.sv
// Directed bench for mips_mem_loader: reset, loads, address wrap, backpressure, control headers, checksum.
module tb_mips_mem_loader;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rdyViol = 0;
  bit   gaps = 1'b0;
  logic [7:0]  tbCsum = 8'd0;
  logic [41:0] wq[$];
  logic [41:0] got;

  mips_mem_loader_if #(.ADDR_W(8)) ldr();

  logic cpuHold, busy, err;

  mips_mem_loader #(.ADDR_W(8)) dut (
    .clk_CPU (clk),
    .rstn_CPU(rstn),
    .loadBus (ldr),
    .cpu_hold(cpuHold),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and check that in_ready is low exactly while writing.
  always begin
    @(posedge clk);
    #1;
    if (rstn) begin
      if (ldr.wr_en === 1'b1) wq.push_back({ldr.wr_sel, ldr.wr_addr, ldr.wr_data});
      if (ldr.in_ready !== !ldr.wr_en) rdyViol++;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    logic rdy;
    int guard = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      ldr.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    forever begin
      ldr.in_valid = 1'b1;
      ldr.in_data  = b;
      rdy = ldr.in_ready;
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: byte %h not accepted, in_ready=%b want 1", b, ldr.in_ready);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    ldr.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendLoad(input logic [7:0] hdr, input logic [7:0] cnt, input logic [7:0] addr);
    tbCsum = 8'd0;
    sendByte(hdr); sendByte(cnt); sendByte(addr);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      tbCsum = tbCsum ^ w[i*8 +: 8];
      sendByte(w[i*8 +: 8]);
    end
  endtask

  task automatic sendCsum;
`ifdef LOADER_CHECKSUM_EN
    sendByte(tbCsum);
`endif
  endtask

  task automatic pulseReset;
    ldr.in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    ldr.in_valid = 1'b0; ldr.in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++; if ({ldr.in_ready, ldr.wr_en, busy, err} !== 4'b0000) begin bad++; $display("FAIL reset_flags: rdy/wr_en/busy/err=%b want 0000", {ldr.in_ready, ldr.wr_en, busy, err}); end
    total++; if ({ldr.wr_sel, ldr.wr_addr, ldr.wr_data} !== 42'd0) begin bad++; $display("FAIL reset_wrport: got %h want 0", {ldr.wr_sel, ldr.wr_addr, ldr.wr_data}); end
    total++; if (cpuHold !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", cpuHold); end
    rstn = 1'b1;
    @(negedge clk);
    total++; if (ldr.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_rdy: got %b want 1", ldr.in_ready); end
    sendByte(8'hFF); idle(1);
    total++; if (cpuHold !== 1'b0) begin bad++; $display("FAIL run_cmd: cpu_hold=%b want 0", cpuHold); end
    pulseReset();
    total++; if (cpuHold !== 1'b1) begin bad++; $display("FAIL reset_rehold: cpu_hold=%b want 1", cpuHold); end
    // Abort a load halfway through its first word.
    sendLoad(8'h00, 8'h00, 8'h10); sendByte(8'h20); sendByte(8'h08);
    ldr.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total++; if ({busy, cpuHold, ldr.in_ready, ldr.wr_en} !== 4'b0100) begin bad++; $display("FAIL midcmd_reset: busy/hold/rdy/wr_en=%b want 0100", {busy, cpuHold, ldr.in_ready, ldr.wr_en}); end
    @(negedge clk); rstn = 1'b1;
    idle(10);
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL midcmd_nowrite: writes=%0d want 0", wq.size()); end
    wq.delete();
  endtask

  task automatic test_instr_load;
    sendLoad(8'h00, 8'h00, 8'h10);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL instr_busy: got %b want 1", busy); end
    sendWord(32'h20080005);
    ldr.in_valid = 1'b0;
    total++; if ({ldr.wr_en, ldr.in_ready} !== 2'b10) begin bad++; $display("FAIL instr_latency: wr_en/rdy=%b want 10", {ldr.wr_en, ldr.in_ready}); end
    total++; if ({ldr.wr_sel, ldr.wr_addr, ldr.wr_data} !== {2'd0, 8'h10, 32'h20080005}) begin bad++; $display("FAIL instr_wrport: got %h want %h", {ldr.wr_sel, ldr.wr_addr, ldr.wr_data}, {2'd0, 8'h10, 32'h20080005}); end
    @(negedge clk);
    total++; if (ldr.wr_en !== 1'b0) begin bad++; $display("FAIL instr_strobe_width: wr_en=%b want 0", ldr.wr_en); end
    sendCsum(); idle(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL instr_done_busy: got %b want 0", busy); end
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL instr_count: writes=%0d want 1", wq.size()); end
    wq.delete();
  endtask

  task automatic test_wrap;
    logic [41:0] exp [4];
    exp[0] = {2'd1, 8'hFF, 32'h11111111};
    exp[1] = {2'd1, 8'h00, 32'h22222222};
    exp[2] = {2'd2, 8'h1F, 32'hAABBCCDD};
    exp[3] = {2'd2, 8'h00, 32'h01234567};
    // Second command follows the first with no idle gap.
    sendLoad(8'h01, 8'h01, 8'hFF); sendWord(32'h11111111); sendWord(32'h22222222); sendCsum();
    sendLoad(8'h02, 8'h01, 8'h1F); sendWord(32'hAABBCCDD); sendWord(32'h01234567); sendCsum();
    idle(4);
    total++; if (wq.size() !== 4) begin bad++; $display("FAIL wrap_count: writes=%0d want 4", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (wq.size() > 0) ? wq.pop_front() : 42'h3FF_FFFF_FFFF;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL wrap_write%0d: got %h want %h", i, got, exp[i]); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure;
    logic [31:0] words [3];
    words[0] = 32'h3C011001; words[1] = 32'h8C220004; words[2] = 32'hAC230008;
    rdyViol = 0;
    gaps = 1'b1;
    sendLoad(8'h00, 8'h02, 8'h40);
    for (int i = 0; i < 3; i++) sendWord(words[i]);
    sendCsum();
    gaps = 1'b0;
    idle(4);
    total++; if (wq.size() !== 3) begin bad++; $display("FAIL bp_count: writes=%0d want 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wq.size() > 0) ? wq.pop_front() : 42'h3FF_FFFF_FFFF;
      total++; if (got !== {2'd0, 8'(8'h40 + i), words[i]}) begin bad++; $display("FAIL bp_write%0d: got %h want %h", i, got, {2'd0, 8'(8'h40 + i), words[i]}); end
    end
    total++; if (rdyViol !== 0) begin bad++; $display("FAIL bp_ready_only_in_write: violations=%0d want 0", rdyViol); end
  endtask

  task automatic test_control;
    sendByte(8'h7A); idle(3);
    total++; if ({err, cpuHold, busy} !== 3'b110) begin bad++; $display("FAIL ctl_badhdr: err/hold/busy=%b want 110", {err, cpuHold, busy}); end
    sendByte(8'hFF); idle(1);
    total++; if ({err, cpuHold} !== 2'b10) begin bad++; $display("FAIL ctl_run: err/hold=%b want 10", {err, cpuHold}); end
    sendByte(8'h00); idle(3);
    total++; if ({err, busy, cpuHold} !== 3'b100) begin bad++; $display("FAIL ctl_load_while_running: err/busy/hold=%b want 100", {err, busy, cpuHold}); end
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL ctl_nowrite: writes=%0d want 0", wq.size()); end
    sendByte(8'hFE); idle(1);
    total++; if (cpuHold !== 1'b1) begin bad++; $display("FAIL ctl_halt: cpu_hold=%b want 1", cpuHold); end
    // Sticky error must not block a later valid load.
    sendLoad(8'h00, 8'h00, 8'h05); sendWord(32'hDEADBEEF); sendCsum(); idle(3);
    got = (wq.size() > 0) ? wq.pop_front() : 42'h3FF_FFFF_FFFF;
    total++; if (got !== {2'd0, 8'h05, 32'hDEADBEEF}) begin bad++; $display("FAIL ctl_load_after_err: got %h want %h", got, {2'd0, 8'h05, 32'hDEADBEEF}); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ctl_err_sticky: got %b want 1", err); end
    wq.delete();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    pulseReset();
    sendLoad(8'h00, 8'h00, 8'h00); sendWord(32'h01020408); sendByte(8'h0F); idle(3);
    total++; if ({err, busy} !== 2'b00) begin bad++; $display("FAIL csum_good: err/busy=%b want 00", {err, busy}); end
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL csum_good_count: writes=%0d want 1", wq.size()); end
    wq.delete();
    sendLoad(8'h00, 8'h00, 8'h00); sendWord(32'h01020408); sendByte(8'h00); idle(3);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_bad_err: got %b want 1", err); end
    got = (wq.size() > 0) ? wq.pop_front() : 42'h3FF_FFFF_FFFF;
    total++; if (got !== {2'd0, 8'h00, 32'h01020408}) begin bad++; $display("FAIL csum_bad_write: got %h want %h", got, {2'd0, 8'h00, 32'h01020408}); end
    wq.delete();
  endtask
`endif

  initial begin
    ldr.in_valid = 1'b0;
    ldr.in_data  = 8'h00;
    test_reset();
    test_instr_load();
    test_wrap();
    test_backpressure();
    test_control();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d want 0", bad);
    $fatal(1);
  end
endmodule

// File: doc/mips_mem_loader.md
# mips_mem_loader

Synthesizable boot/memory loader for the MIPS core: the hardware writer for the instruction memory, data memory and register bank that simulation preloads from `.mem` files. It accepts a byte stream over a valid/ready handshake, parses load commands, assembles big-endian 32-bit words and issues single-cycle write strobes into the selected storage. It holds the CPU in reset until a run command arrives.

## Interface
- ADDR_W, 8, word-address width of the write port; addresses wrap modulo 2^ADDR_W.
- clk_CPU  input  1  system clock, all state on rising edge.
- rstn_CPU  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid & in_ready at the clock edge.
- wr_en  output  1  one-cycle write strobe.
- wr_sel  output  2  target: 0 instruction memory, 1 data memory, 2 register bank.
- wr_addr  output  ADDR_W  word address.
- wr_data  output  32  word to write.
- cpu_hold  output  1  1 = CPU held in reset.
- busy  output  1  command in progress (state ≠ IDLE).
- err  output  1  sticky error flag.

## Operation
- States: IDLE, COUNT, ADDR, DATA, WRITE, CHK (only with checksum), all encoded in one state register.
- IDLE: consumes a header byte. 0x00/0x01/0x02 → latch wr_sel, go COUNT; 0xFF → cpu_hold←0, stay IDLE; 0xFE → cpu_hold←1, stay IDLE; any other value → err←1, stay IDLE.
- Load header received while cpu_hold=0 → err←1, command ignored, stay IDLE (no writes to a running CPU).
- COUNT: byte N latched; word count = N+1 (1..256). → ADDR.
- ADDR: byte latched as start address (zero-extended / truncated to ADDR_W). → DATA, byte index 0.
- DATA: four bytes accepted, MSB first, shifted into the word register; after the 4th byte → WRITE.
- WRITE: wr_en=1 for exactly one cycle with current wr_addr/wr_data; in_ready=0; word counter decrements; address increments modulo 2^ADDR_W (modulo 32 when wr_sel=2). If words remain → DATA, else → CHK (if enabled) or IDLE.
- Register bank target: writes with wr_addr=0 are still issued; the register bank ignores them.
- err clears only on reset. err never blocks further commands.

## Timing
- Reset values: state IDLE, in_ready 0 during reset then 1, wr_en 0, wr_sel 0, wr_addr 0, wr_data 0, cpu_hold 1, busy 0, err 0.
- in_ready = 1 in every state except WRITE; it is a registered-state decode, no combinational path from in_valid.
- Latency: wr_en asserts the cycle after the 4th data byte handshake.
- Minimum load of K words: 3 + 5K cycles at full stream rate.
- wr_addr/wr_data/wr_sel hold stable outside WRITE; consumers sample only on wr_en.
- Stalls (in_valid=0) in any state hold all state indefinitely.
- Reset mid-command: abort immediately, no partial write, cpu_hold back to 1.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last WRITE the loader enters CHK and consumes one byte; it must equal the XOR of all payload data bytes of the command; mismatch → err←1. Writes already issued are not reverted. Then → IDLE.
- Undefined: no CHK state; last WRITE goes straight to IDLE; no trailing byte expected.

## Test plan
- Reset: rstn_CPU low mid-stream → all outputs at reset values, cpu_hold=1, no wr_en.
- Instruction load: 00,00,10, 20 08 00 05 → single wr_en with wr_sel=0, wr_addr=0x10, wr_data=0x20080005, then busy=0.
- Wrap: data load 01,01,FF, words 0x11111111, 0x22222222 → writes at addr 0xFF then 0x00; register-bank load 02,01,1F → addrs 31 then 0.
- Backpressure: in_valid toggled randomly during a 3-word load → identical wr_en sequence, in_ready=0 exactly in WRITE cycles.
- Control: header 0x7A → err=1, no write; FF → cpu_hold=0; subsequent 00 header → err stays 1, no write; FE → cpu_hold=1.
- With LOADER_CHECKSUM_EN: 00,00,00, 01 02 04 08, checksum 0x0F → err=0; checksum 0x00 → write still issued, err=1.
